// File: rtl/mips_defs.sv
// Shared MIPS encodings: opcodes, instruction field ranges, W-stage byte-extend
// selectors and small opcode classifiers used by the memory stage.
package mips_defs;

    localparam int OP_HI = 31;
    localparam int OP_LO = 26;
    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;
    localparam int RD_HI = 15;
    localparam int RD_LO = 11;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_LB      = 6'b100000;
    localparam logic [5:0] OP_LH      = 6'b100001;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_LBU     = 6'b100100;
    localparam logic [5:0] OP_LHU     = 6'b100101;
    localparam logic [5:0] OP_SB      = 6'b101000;
    localparam logic [5:0] OP_SH      = 6'b101001;
    localparam logic [5:0] OP_SW      = 6'b101011;

    localparam logic [5:0] FN_ADDU    = 6'b100001;
    localparam logic [5:0] FN_SUBU    = 6'b100011;

    // W-stage byte/half select-and-extend operation codes
    localparam logic [2:0] BEXT_WORD  = 3'b000;
    localparam logic [2:0] BEXT_LBU   = 3'b001;
    localparam logic [2:0] BEXT_LB    = 3'b010;
    localparam logic [2:0] BEXT_LHU   = 3'b101;
    localparam logic [2:0] BEXT_LH    = 3'b110;

    function automatic logic is_load_op(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
               (op == OP_LHU) || (op == OP_LW);
    endfunction

    function automatic logic is_store_op(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/store_lane_gen.sv
// Combinational lane generator: byte enables, replicated store data and the
// alignment check for the access size implied by the opcode.
module store_lane_gen
    import mips_defs::*;
(
    input  logic [5:0]  i_op,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_lane_data,
    output logic        o_misalign
);

    always_comb begin
        o_be        = 4'b0000;
        o_lane_data = i_wdata;
        o_misalign  = 1'b0;
        case (i_op)
            OP_SW: begin
                o_be       = 4'b1111;
                o_misalign = |i_addr_lo;
            end
            OP_SH: begin
                o_be        = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_lane_data = {2{i_wdata[15:0]}};
                o_misalign  = i_addr_lo[0];
            end
            OP_SB: begin
                o_be        = 4'b0001 << i_addr_lo;
                o_lane_data = {4{i_wdata[7:0]}};
            end
            OP_LW:        o_misalign = |i_addr_lo;
            OP_LH, OP_LHU: o_misalign = i_addr_lo[0];
            default: ;
        endcase
    end

endmodule

// File: rtl/dm_store_unit.sv
// M-stage data memory: byte-enabled stores, raw word reads registered into W,
// plus registered address-error flags and lane select for the W-stage extender.
module dm_store_unit
    import mips_defs::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_M,
    input  logic [31:0] addr_M,
    input  logic [31:0] wdata_M,
    output logic [31:0] DMout_W,
    output logic [1:0]  ByteSel_W,
    output logic [3:0]  BE_M,
    output logic        AdEL_W,
    output logic        AdES_W
);

    logic [5:0]    w_op;
    logic          w_is_load;
    logic          w_is_store;
    logic          w_in_range;
    logic          w_misalign;
    logic          w_load_ok;
    logic          w_store_ok;
    logic [3:0]    w_lane_be;
    logic [31:0]   w_lane_data;
    logic [AW-1:0] w_index;
    logic [31:0]   w_rd_word;
    logic          w_unused;

    assign w_op       = instr_M[OP_HI:OP_LO];
    assign w_is_load  = is_load_op(w_op);
    assign w_is_store = is_store_op(w_op);
    assign w_index    = addr_M[AW+1:2];
    assign w_in_range = (addr_M[31:AW+2] == '0);
    assign w_unused   = ^instr_M[OP_LO-1:0];

    store_lane_gen u_lane_gen (
        .i_op        (w_op),
        .i_addr_lo   (addr_M[1:0]),
        .i_wdata     (wdata_M),
        .o_be        (w_lane_be),
        .o_lane_data (w_lane_data),
        .o_misalign  (w_misalign)
    );

    assign w_load_ok  = w_is_load  && w_in_range && !w_misalign;
    assign w_store_ok = w_is_store && w_in_range && !w_misalign;
    assign BE_M       = w_store_ok ? w_lane_be : 4'b0000;

    // One byte-wide array per lane so each enable drives its own write port
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_mem [DEPTH];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        r_mem[k] <= 8'h00;
                    end
                end else if (BE_M[gi]) begin
                    r_mem[w_index] <= w_lane_data[8*gi +: 8];
                end
            end

            assign w_rd_word[8*gi +: 8] = r_mem[w_index];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            DMout_W   <= 32'h0;
            ByteSel_W <= 2'b00;
            AdEL_W    <= 1'b0;
            AdES_W    <= 1'b0;
        end else begin
            DMout_W   <= w_load_ok ? w_rd_word : 32'h0;
            ByteSel_W <= addr_M[1:0];
            AdEL_W    <= w_is_load  && !w_load_ok;
            AdES_W    <= w_is_store && !w_store_ok;
        end
    end

endmodule
